// File: rtl/ethernet_reply_pkg.sv
// Shared constants and state encoding for the UDP reply assembler.
// The preamble and SFD are prepended to every latched reply header.
package ethernet_reply_pkg;

  localparam int HEAD_BYTES     = 42;
  localparam int PREAMBLE_BYTES = 8;
  localparam logic [PREAMBLE_BYTES*8-1:0] PREAMBLE_SFD = 64'h55555555555555D5;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t COLLECT = 2'd1;
  localparam state_t HOLD    = 2'd2;
  localparam state_t DROP    = 2'd3;

endpackage

// File: rtl/ethernet_beat_packer.sv
// Places the lanes of one payload beat into the left-aligned payload buffer,
// starting at byte index count_i and never writing past size_i.
module ethernet_beat_packer #(
  parameter int DATA_BYTES  = 1,
  parameter int MAX_PAYLOAD = 63
) (
  input  logic [MAX_PAYLOAD*8-1:0] payload_i,
  input  logic [DATA_BYTES*8-1:0]  data_i,
  input  logic [15:0]              count_i,
  input  logic [15:0]              size_i,
  output logic [MAX_PAYLOAD*8-1:0] payload_o,
  output logic [15:0]              added_o
);

  logic [15:0] remain;

  assign remain = size_i - count_i;

  // Lane 0 is the most significant lane and carries the earliest byte.
  always_comb begin
    added_o   = (remain < 16'(DATA_BYTES)) ? remain : 16'(DATA_BYTES);
    payload_o = payload_i;
    for (int p = 0; p < MAX_PAYLOAD; p++) begin
      if ((p >= int'(count_i)) && (p < int'(count_i) + int'(added_o))) begin
        payload_o[MAX_PAYLOAD*8-1-8*p -: 8] =
          data_i[(DATA_BYTES-1-(p-int'(count_i)))*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/ethernet_udp_reply_assembler.sv
// Collects a UDP payload beat by beat, pairs it with a preamble-prefixed reply
// header and holds the complete reply until the consumer acknowledges it.
module ethernet_udp_reply_assembler
  import ethernet_reply_pkg::*;
#(
  parameter int DATA_BYTES  = 1,
  parameter int MAX_PAYLOAD = 63
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_udp_valid,
  input  logic [DATA_BYTES*8-1:0]              i_udp_data,
  input  logic                                 i_udp_last,
  input  logic [15:0]                          i_udp_payload_size,
  input  logic [HEAD_BYTES*8-1:0]              i_udp_reply_head,
  output logic                                 o_udp_ready,
  output logic                                 o_udp_reply_valid,
  output logic [(PREAMBLE_BYTES+HEAD_BYTES)*8-1:0] o_udp_reply_head,
  output logic [MAX_PAYLOAD*8-1:0]             o_udp_reply_payload,
  output logic [15:0]                          o_udp_payload_size,
  input  logic                                 i_udp_reply_ack,
  output logic                                 o_udp_error
);

  localparam int          HEAD_W     = (PREAMBLE_BYTES + HEAD_BYTES) * 8;
  localparam int          PAY_W      = MAX_PAYLOAD * 8;
  localparam logic [15:0] BEAT_BYTES = 16'(DATA_BYTES);
  localparam logic [15:0] MAX_SIZE   = 16'(MAX_PAYLOAD);

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       size_q, size_d;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [PAY_W-1:0]  payload_q, payload_d;
  logic              err_q, err_d;

  logic              accept;
  logic              first_beat;
  logic [PAY_W-1:0]  pack_base, pack_out;
  logic [15:0]       pack_count, pack_size, pack_added, filled;
  logic [16:0]       drop_sum;
  logic              size_bad;

  assign o_udp_ready = (state_q != HOLD) && !i_reset;
  assign accept      = i_udp_valid && o_udp_ready;
  assign first_beat  = (state_q == IDLE);

  // A new frame packs into an empty buffer against the live size input.
  assign pack_base  = first_beat ? '0 : payload_q;
  assign pack_count = first_beat ? 16'd0 : count_q;
  assign pack_size  = first_beat ? i_udp_payload_size : size_q;
  assign filled     = pack_count + pack_added;
  assign drop_sum   = {1'b0, count_q} + {1'b0, BEAT_BYTES};
  assign size_bad   = (i_udp_payload_size == 16'd0) || (i_udp_payload_size > MAX_SIZE);

  ethernet_beat_packer #(
    .DATA_BYTES (DATA_BYTES),
    .MAX_PAYLOAD(MAX_PAYLOAD)
  ) u_packer (
    .payload_i(pack_base),
    .data_i   (i_udp_data),
    .count_i  (pack_count),
    .size_i   (pack_size),
    .payload_o(pack_out),
    .added_o  (pack_added)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    size_d    = size_q;
    head_d    = head_q;
    payload_d = payload_q;
    err_d     = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          head_d    = {PREAMBLE_SFD, i_udp_reply_head};
          size_d    = i_udp_payload_size;
          payload_d = '0;
          // A bad frame that is already over after one beat errors without visiting DROP.
          if (size_bad) begin
            if (i_udp_last || (i_udp_payload_size <= BEAT_BYTES)) begin
              err_d   = 1'b1;
              count_d = 16'd0;
            end else begin
              state_d = DROP;
              count_d = BEAT_BYTES;
            end
          end else begin
            payload_d = pack_out;
            count_d   = filled;
            if (filled == i_udp_payload_size) begin
              state_d = HOLD;
            end else if (i_udp_last) begin
              err_d   = 1'b1;
              count_d = 16'd0;
            end else begin
              state_d = COLLECT;
            end
          end
        end
        COLLECT: begin
          payload_d = pack_out;
          count_d   = filled;
          if (filled == size_q) begin
            state_d = HOLD;
          end else if (i_udp_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
            count_d = 16'd0;
          end
        end
        DROP: begin
          if ((drop_sum >= {1'b0, size_q}) || i_udp_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
            count_d = 16'd0;
          end else begin
            count_d = drop_sum[15:0];
          end
        end
        default: ;
      endcase
    end else if ((state_q == HOLD) && i_udp_reply_ack) begin
      state_d = IDLE;
      count_d = 16'd0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      count_q   <= 16'd0;
      size_q    <= 16'd0;
      head_q    <= '0;
      payload_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      size_q    <= size_d;
      head_q    <= head_d;
      payload_q <= payload_d;
      err_q     <= err_d;
    end
  end

  assign o_udp_reply_valid   = (state_q == HOLD);
  assign o_udp_reply_head    = head_q;
  assign o_udp_reply_payload = payload_q;
  assign o_udp_payload_size  = size_q;
  assign o_udp_error         = err_q;

endmodule

// File: tb/tb_ethernet_udp_reply_assembler.sv
// Directed bench: a 1-byte-lane and a 4-byte-lane assembler driven by frame
// tasks, with a frame-level model checked on every falling edge.
module tb_ethernet_udp_reply_assembler;

  localparam int MAX1 = 63;
  localparam int MAX4 = 16;
  localparam logic [63:0] PRE = 64'h55555555555555D5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               v1, l1, a1, r1, rv1, e1;
  logic [7:0]         d1;
  logic [15:0]        sz1, os1;
  logic [335:0]       hd1;
  logic [399:0]       oh1;
  logic [MAX1*8-1:0]  op1;

  logic               v4, l4, a4, r4, rv4, e4;
  logic [31:0]        d4;
  logic [15:0]        sz4, os4;
  logic [335:0]       hd4;
  logic [399:0]       oh4;
  logic [MAX4*8-1:0]  op4;

  ethernet_udp_reply_assembler #(.DATA_BYTES(1), .MAX_PAYLOAD(MAX1)) u1 (
    .i_clk(clk), .i_reset(rst), .i_udp_valid(v1), .i_udp_data(d1), .i_udp_last(l1),
    .i_udp_payload_size(sz1), .i_udp_reply_head(hd1), .o_udp_ready(r1),
    .o_udp_reply_valid(rv1), .o_udp_reply_head(oh1), .o_udp_reply_payload(op1),
    .o_udp_payload_size(os1), .i_udp_reply_ack(a1), .o_udp_error(e1));

  ethernet_udp_reply_assembler #(.DATA_BYTES(4), .MAX_PAYLOAD(MAX4)) u4 (
    .i_clk(clk), .i_reset(rst), .i_udp_valid(v4), .i_udp_data(d4), .i_udp_last(l4),
    .i_udp_payload_size(sz4), .i_udp_reply_head(hd4), .o_udp_ready(r4),
    .o_udp_reply_valid(rv4), .o_udp_reply_head(oh4), .o_udp_reply_payload(op4),
    .o_udp_payload_size(os4), .i_udp_reply_ack(a4), .o_udp_error(e4));

  byte unsigned      frameBytes [0:255];
  bit                expReady [2];
  bit                expValid [2];
  bit                expErr [2];
  logic [399:0]      expHead [2];
  logic [15:0]       expSize [2];
  logic [63*8-1:0]   expPay [2];
  bit                checkOn;
  int                nChecks = 0;
  int                nBad = 0;
  int                errCount1 = 0;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    nChecks++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model compare: control outputs every cycle, reply contents whenever a reply is held.
  always @(negedge clk) begin
    if (e1 === 1'b1) errCount1++;
    if (checkOn) begin
      checkOutput("ready1", 512'(r1), 512'(expReady[0]));
      checkOutput("valid1", 512'(rv1), 512'(expValid[0]));
      checkOutput("error1", 512'(e1), 512'(expErr[0]));
      checkOutput("ready4", 512'(r4), 512'(expReady[1]));
      checkOutput("valid4", 512'(rv4), 512'(expValid[1]));
      checkOutput("error4", 512'(e4), 512'(expErr[1]));
      if (expValid[0]) begin
        checkOutput("head1", 512'(oh1), 512'(expHead[0]));
        checkOutput("size1", 512'(os1), 512'(expSize[0]));
        checkOutput("payload1", 512'(op1), 512'(expPay[0]));
      end
      if (expValid[1]) begin
        checkOutput("head4", 512'(oh4), 512'(expHead[1]));
        checkOutput("size4", 512'(os4), 512'(expSize[1]));
        checkOutput("payload4", 512'({op4, {((MAX1-MAX4)*8){1'b0}}}), 512'(expPay[1]));
      end
    end
  end

  function automatic logic [335:0] headFor(input int size);
    logic [335:0] h;
    for (int i = 0; i < 42; i++) h[335-8*i -: 8] = 8'(size + 7*i + 3);
    return h;
  endfunction

  task automatic driveIn(input int s, input bit v, input logic [31:0] d, input bit l,
                         input logic [15:0] sz, input logic [335:0] hd, input bit a);
    if (s == 0) begin
      v1 = v; d1 = d[7:0]; l1 = l; sz1 = sz; hd1 = hd; a1 = a;
    end else begin
      v4 = v; d4 = d; l4 = l; sz4 = sz; hd4 = hd; a4 = a;
    end
  endtask

  task automatic fillBytes();
    for (int i = 0; i < 256; i++) frameBytes[i] = 8'($urandom_range(1, 255));
  endtask

  // Acknowledge while offering a beat that must not be taken.
  task automatic ackReply(input int s);
    driveIn(s, 1'b1, 32'h01020304, 1'b0, 16'd1, headFor(1), 1'b1);
    @(posedge clk); #1;
    expValid[s] = 1'b0;
    expReady[s] = 1'b1;
    driveIn(s, 1'b0, 32'h0, 1'b0, 16'd0, '0, 1'b0);
  endtask

  task automatic applyStimulus(input int s, input int size, input int nBeats, input int lastIdx,
                               input int holdCycles, input bit doAck);
    int db = (s == 0) ? 1 : 4;
    int mx = (s == 0) ? MAX1 : MAX4;
    bit bad = (size == 0) || (size > mx);
    bit ended = 1'b0;
    bit ok = 1'b0;
    logic [31:0] d;
    logic [335:0] hd = headFor(size);
    for (int k = 0; k < nBeats && !ended; k++) begin
      d = '0;
      for (int l = 0; l < db; l++) d[(db-1-l)*8 +: 8] = frameBytes[k*db+l];
      driveIn(s, 1'b1, d, k == lastIdx, 16'(size), hd, 1'b0);
      @(posedge clk); #1;
      if (((k+1)*db >= size) && !bad) begin
        ok = 1'b1;
        ended = 1'b1;
      end else if (((k+1)*db >= size) || (k == lastIdx)) begin
        ended = 1'b1;
      end
      if (ok) begin
        expValid[s] = 1'b1;
        expReady[s] = 1'b0;
        expHead[s]  = {PRE, hd};
        expSize[s]  = 16'(size);
        expPay[s]   = '0;
        for (int i = 0; i < size; i++) expPay[s][63*8-1-8*i -: 8] = frameBytes[i];
      end else if (ended) begin
        expErr[s] = 1'b1;
      end
    end
    if (ok) begin
      for (int c = 0; c < holdCycles; c++) begin
        driveIn(s, 1'b1, 32'hDEADBEEF, 1'b1, 16'd3, headFor(99), 1'b0);
        @(posedge clk); #1;
      end
    end
    driveIn(s, 1'b0, 32'h0, 1'b0, 16'(size), hd, 1'b0);
    if (ended && !ok) begin
      @(posedge clk); #1;
      expErr[s] = 1'b0;
    end
    if (ok && doAck) ackReply(s);
  endtask

  initial begin
    int errBase;
    rst = 1'b1;
    checkOn = 1'b0;
    driveIn(0, 1'b0, 32'h0, 1'b0, 16'd0, '0, 1'b0);
    driveIn(1, 1'b0, 32'h0, 1'b0, 16'd0, '0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      expReady[s] = 1'b0; expValid[s] = 1'b0; expErr[s] = 1'b0;
      expHead[s] = '0; expSize[s] = '0; expPay[s] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready1", 512'(r1), 512'(0));
    checkOutput("rst_valid1", 512'(rv1), 512'(0));
    checkOutput("rst_head1", 512'(oh1), 512'(0));
    checkOutput("rst_payload1", 512'(op1), 512'(0));
    checkOutput("rst_error4", 512'(e4), 512'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    expReady[0] = 1'b1; expReady[1] = 1'b1;
    checkOn = 1'b1;
    @(posedge clk); #1;

    // Four single-byte beats; reply contents also pinned to literal values.
    frameBytes[0] = 8'h11; frameBytes[1] = 8'h22; frameBytes[2] = 8'h33; frameBytes[3] = 8'h44;
    applyStimulus(0, 4, 4, 3, 0, 1'b0);
    @(negedge clk); #1;
    checkOutput("lit_payload_top", 512'(op1[MAX1*8-1 -: 32]), 512'(32'h11223344));
    checkOutput("lit_payload_rest", 512'(op1[MAX1*8-33:0]), 512'(0));
    checkOutput("lit_head_pre", 512'(oh1[399 -: 64]), 512'(64'h55555555555555D5));
    checkOutput("lit_size", 512'(os1), 512'(4));
    ackReply(0);

    // Ack while idle changes nothing.
    repeat (3) begin
      driveIn(0, 1'b0, 32'h0, 1'b0, 16'd0, '0, 1'b1);
      @(posedge clk); #1;
    end
    driveIn(0, 1'b0, 32'h0, 1'b0, 16'd0, '0, 1'b0);

    // Wide lanes: excess lanes of the last beat discarded.
    frameBytes[0] = 8'hAA; frameBytes[1] = 8'hBB; frameBytes[2] = 8'hCC; frameBytes[3] = 8'hDD;
    frameBytes[4] = 8'hEE; frameBytes[5] = 8'hFF; frameBytes[6] = 8'h01; frameBytes[7] = 8'h02;
    applyStimulus(1, 6, 2, 1, 0, 1'b0);
    @(negedge clk); #1;
    checkOutput("lit4_payload_top", 512'(op4[MAX4*8-1 -: 48]), 512'(48'hAABBCCDDEEFF));
    checkOutput("lit4_payload_rest", 512'(op4[MAX4*8-49:0]), 512'(0));
    checkOutput("lit4_size", 512'(os4), 512'(6));
    ackReply(1);

    fillBytes(); applyStimulus(1, 16, 4, 3, 0, 1'b1);
    fillBytes(); applyStimulus(1, 3, 1, -1, 0, 1'b1);
    fillBytes(); applyStimulus(1, 0, 1, -1, 0, 1'b1);
    fillBytes(); applyStimulus(1, 20, 5, -1, 0, 1'b1);
    fillBytes(); applyStimulus(1, 5, 2, 0, 0, 1'b1);
    fillBytes(); applyStimulus(1, 9, 3, 2, 0, 1'b1);

    // Oversized frame is swallowed whole with exactly one error pulse.
    errBase = errCount1;
    fillBytes(); applyStimulus(0, 70, 70, -1, 0, 1'b1);
    @(negedge clk); #1;
    checkOutput("drop_error_pulses", 512'(errCount1 - errBase), 512'(1));

    fillBytes(); applyStimulus(0, 64, 40, 10, 0, 1'b1);
    fillBytes(); applyStimulus(0, 5, 5, 2, 0, 1'b1);
    fillBytes(); applyStimulus(0, 2, 2, 1, 0, 1'b1);
    fillBytes(); applyStimulus(0, 3, 3, -1, 20, 1'b1);
    fillBytes(); applyStimulus(0, 63, 63, 62, 0, 1'b1);
    fillBytes(); applyStimulus(0, 1, 1, 0, 0, 1'b1);

    // Reset in the middle of a frame.
    fillBytes(); applyStimulus(0, 4, 2, -1, 0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    expReady[0] = 1'b0; expReady[1] = 1'b0;
    @(negedge clk); #1;
    checkOutput("midrst_head", 512'(oh1), 512'(0));
    checkOutput("midrst_payload", 512'(op1), 512'(0));
    checkOutput("midrst_size", 512'(os1), 512'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    expReady[0] = 1'b1; expReady[1] = 1'b1;
    @(posedge clk); #1;
    fillBytes(); applyStimulus(0, 4, 4, 3, 0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/ethernet_udp_reply_assembler.md
ETHERNET_UDP_REPLY_ASSEMBLER -- requirements
Module: ethernet_udp_reply_assembler

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 1, payload bytes per input beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 63, payload buffer capacity in bytes; it SHALL be a multiple of DATA_BYTES or DATA_BYTES=1.
REQ-003 SHALL have ports: i_clk input 1 clock; i_reset input 1 reset, asynchronous, active-high.
REQ-004 SHALL have ports: i_udp_valid input 1 beat valid; i_udp_data input DATA_BYTES*8 payload beat, MSB lane first on wire; i_udp_last input 1 final beat of frame.
REQ-005 SHALL have ports: i_udp_payload_size input 16 frame payload length in bytes; i_udp_reply_head input 42*8 Eth/IP/UDP reply header.
REQ-006 SHALL have ports: o_udp_ready output 1 beat accepted when valid&ready; o_udp_reply_valid output 1 reply held.
REQ-007 SHALL have ports: o_udp_reply_head output 50*8 preamble+SFD+header; o_udp_reply_payload output MAX_PAYLOAD*8 left-aligned payload; o_udp_payload_size output 16.
REQ-008 SHALL have ports: i_udp_reply_ack input 1 consumer release; o_udp_error output 1 one-cycle error pulse.

Function
REQ-009 SHALL implement states IDLE, COLLECT, HOLD, DROP.
REQ-010 o_udp_ready SHALL be 1 in IDLE, COLLECT and DROP, and 0 in HOLD or while i_reset is high.
REQ-011 First accepted beat in IDLE SHALL latch {64'h55555555555555D5, i_udp_reply_head} into o_udp_reply_head and i_udp_payload_size into o_udp_payload_size.
REQ-012 On that first beat: size 0 or size > MAX_PAYLOAD -> DROP; otherwise the beat's bytes are stored -> COLLECT, or directly -> HOLD if the frame completes.
REQ-013 Each accepted beat SHALL add min(DATA_BYTES, size - count) bytes; excess lanes of the final beat SHALL be discarded.
REQ-014 Payload byte i SHALL appear at o_udp_reply_payload[MAX_PAYLOAD*8-1-8i -: 8]; bytes at index >= size SHALL read 0.
REQ-015 When count reaches size, next state SHALL be HOLD, with o_udp_reply_valid high the cycle after the final beat is accepted.
REQ-016 In HOLD, all o_udp_reply_* outputs SHALL be stable until i_udp_reply_ack; ack -> IDLE, with valid low the next cycle.
REQ-017 i_udp_last on an accepted beat before count reaches size SHALL pulse o_udp_error, discard the frame and return to IDLE.
REQ-018 i_udp_last absent on the completing beat SHALL NOT be an error; size governs completion.
REQ-019 DROP SHALL consume beats until ceil(size/DATA_BYTES) beats or i_udp_last, then pulse o_udp_error and return to IDLE; o_udp_reply_valid stays 0.
REQ-020 Byte counter SHALL be 16 bits with no wrap-around; compare against the latched size, not the live input.
REQ-021 i_udp_reply_ack outside HOLD SHALL be ignored.
REQ-022 A beat presented in the same cycle as ack in HOLD SHALL NOT be accepted.

Reset
REQ-023 i_reset SHALL asynchronously force IDLE, clear count, and zero o_udp_reply_head, o_udp_reply_payload, o_udp_payload_size, o_udp_reply_valid and o_udp_error.
REQ-024 Reset mid-COLLECT or mid-HOLD SHALL discard the frame with no error pulse; first beat after release starts a new frame.

Structure
REQ-025 Shared package ethernet_reply_pkg SHALL hold: preamble/SFD constant 64'h55555555555555D5, HEAD_BYTES=42, PREAMBLE_BYTES=8, state typedef.
REQ-026 Beat-to-buffer lane packing SHALL live in one sub-module, ethernet_beat_packer, parametrised by DATA_BYTES and MAX_PAYLOAD.

Verification
REQ-027 DATA_BYTES=1, size=4, bytes 11,22,33,44 -> valid 1 cycle after 4th beat; payload top 4 bytes 11223344, rest 0; head top 8 bytes 55555555555555D5.
REQ-028 DATA_BYTES=4, size=6, beats AABBCCDD, EEFF0102 -> payload top bytes AABBCCDDEEFF, lanes 0102 dropped, o_udp_payload_size=6.
REQ-029 Size 70 with MAX_PAYLOAD 63, DATA_BYTES=1 -> 70 beats consumed in DROP, error pulse once, valid never high.
REQ-030 Size 5, i_udp_last on beat 3 -> error pulse, IDLE; the next 2-byte frame completes correctly.
REQ-031 HOLD without ack for 20 cycles while valid beats are driven -> ready 0, outputs unchanged; ack -> valid low next cycle, following beat accepted.
REQ-032 i_reset pulse after 2 of 4 beats -> all outputs 0; a new 4-byte frame after release is assembled correctly.
